// File: rtl/regfile_init_bypass_if.sv
// regfile_init_bypass_if: signal bundle between the datapath and the register file
// Ports (master = datapath, slave = register file):
//   clear_req, reg_write_en, destination_reg, write_data, source1_reg, source2_reg  master -> slave
//   read_data1, read_data2, init_busy, wr_drop                                      slave -> master
//   inject_par_err (master -> slave), parity_err1/2 (slave -> master) with REGFILE_PARITY_EN
interface regfile_init_bypass_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH      = 32
);
  logic                  clear_req;
  logic                  reg_write_en;
  logic [ADDR_WIDTH-1:0] destination_reg;
  logic [WIDTH-1:0]      write_data;
  logic [ADDR_WIDTH-1:0] source1_reg;
  logic [ADDR_WIDTH-1:0] source2_reg;
  logic [WIDTH-1:0]      read_data1;
  logic [WIDTH-1:0]      read_data2;
  logic                  init_busy;
  logic                  wr_drop;
`ifdef REGFILE_PARITY_EN
  logic                  inject_par_err;
  logic                  parity_err1;
  logic                  parity_err2;
`endif
  modport master (
    output clear_req, reg_write_en, destination_reg, write_data, source1_reg, source2_reg,
    input  read_data1, read_data2, init_busy, wr_drop
`ifdef REGFILE_PARITY_EN
    , output inject_par_err, input parity_err1, parity_err2
`endif
  );
  modport slave (
    input  clear_req, reg_write_en, destination_reg, write_data, source1_reg, source2_reg,
    output read_data1, read_data2, init_busy, wr_drop
`ifdef REGFILE_PARITY_EN
    , input inject_par_err, output parity_err1, parity_err2
`endif
  );
endinterface

// File: rtl/regfile_init_bypass.sv
// regfile_init_bypass: 2-read/1-write register file with hardware clear, bypass and range protection
// Ports: clk, rst_n (async active-low), bus (regfile_init_bypass_if.slave).
// Optional macro REGFILE_PARITY_EN adds a stored even-parity bit per entry with error injection/reporting.
module regfile_init_bypass #(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ZERO_REG   = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_init_bypass_if.slave bus
);
  typedef enum logic {INIT, READY} state_t;
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  drop_q, drop_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic                  ready, dst_ok, wr_ok;
  logic                  byp1, byp2, arr1, arr2;
  assign ready  = state_q == READY;
  assign dst_ok = {1'b0, bus.destination_reg} < DEPTH_W;
  assign wr_ok  = ready && bus.reg_write_en && dst_ok &&
                  !(ZERO_REG != 0 && bus.destination_reg == '0);
  // wr_ok already implies the destination passes every read-rule guard, so a match is a bypass
  assign byp1 = wr_ok && bus.destination_reg == bus.source1_reg;
  assign byp2 = wr_ok && bus.destination_reg == bus.source2_reg;
  assign arr1 = ready && !byp1 && ({1'b0, bus.source1_reg} < DEPTH_W) &&
                !(ZERO_REG != 0 && bus.source1_reg == '0);
  assign arr2 = ready && !byp2 && ({1'b0, bus.source2_reg} < DEPTH_W) &&
                !(ZERO_REG != 0 && bus.source2_reg == '0);
  assign bus.read_data1 = byp1 ? bus.write_data : arr1 ? mem_q[bus.source1_reg[IW-1:0]] : '0;
  assign bus.read_data2 = byp2 ? bus.write_data : arr2 ? mem_q[bus.source2_reg[IW-1:0]] : '0;
  assign bus.init_busy  = !ready;
  assign bus.wr_drop    = drop_q;
  always_comb begin
    state_d = (state_q == INIT) ? ((idx_q == LAST) ? READY : INIT) : (bus.clear_req ? INIT : READY);
    idx_d   = (state_q == INIT) ? idx_q + 1'b1 : '0;
    drop_d  = bus.reg_write_en && (!ready || !dst_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end
  // storage is not reset; the sequencer zeroes it one entry per cycle once reset is released
  always_ff @(posedge clk) begin
    if (rst_n && !ready)
      mem_q[idx_q[IW-1:0]] <= '0;
    else if (wr_ok)
      mem_q[bus.destination_reg[IW-1:0]] <= bus.write_data;
  end
`ifdef REGFILE_PARITY_EN
  logic par_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst_n && !ready)
      par_q[idx_q[IW-1:0]] <= 1'b0;
    else if (wr_ok)
      par_q[bus.destination_reg[IW-1:0]] <= ^bus.write_data ^ bus.inject_par_err;
  end
  assign bus.parity_err1 = arr1 && ((^mem_q[bus.source1_reg[IW-1:0]]) != par_q[bus.source1_reg[IW-1:0]]);
  assign bus.parity_err2 = arr2 && ((^mem_q[bus.source2_reg[IW-1:0]]) != par_q[bus.source2_reg[IW-1:0]]);
`endif
endmodule

// File: tb/tb_regfile_init_bypass.sv
// tb_regfile_init_bypass: directed checks on default, ZERO_REG=0 and DEPTH=16 instances
module tb_regfile_init_bypass;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0, we = 1'b0;
  logic [4:0]  dst = '0, s1 = '0, s2 = '0;
  logic [31:0] wd = '0;
  int          total = 0, bad = 0, busy0, busy2;
  always #5 clk = ~clk;
  regfile_init_bypass_if i0 (), i1 (), i2 ();
  assign {i0.clear_req, i0.reg_write_en, i0.destination_reg, i0.write_data, i0.source1_reg, i0.source2_reg} = {ce, we, dst, wd, s1, s2};
  assign {i1.clear_req, i1.reg_write_en, i1.destination_reg, i1.write_data, i1.source1_reg, i1.source2_reg} = {ce, we, dst, wd, s1, s2};
  assign {i2.clear_req, i2.reg_write_en, i2.destination_reg, i2.write_data, i2.source1_reg, i2.source2_reg} = {ce, we, dst, wd, s1, s2};
`ifdef REGFILE_PARITY_EN
  logic inj = 1'b0;
  assign i0.inject_par_err = inj;
  assign i1.inject_par_err = inj;
  assign i2.inject_par_err = inj;
`endif
  regfile_init_bypass u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  regfile_init_bypass #(.ZERO_REG(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  regfile_init_bypass #(.DEPTH(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic c, input logic w, input logic [4:0] d, input logic [31:0] x,
                     input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    ce = c; we = w; dst = d; wd = x; s1 = a; s2 = b;
    #1;
  endtask
  initial begin
    drv(0, 0, 0, 0, 3, 4);
    chk("rst_busy", 32'(i0.init_busy), 1);
    chk("rst_rd1", i0.read_data1, 0);
    chk("rst_rd2", i0.read_data2, 0);
    chk("rst_drop", 32'(i0.wr_drop), 0);
    rst_n = 1'b1;
    busy0 = 1; busy2 = 1;
    for (int k = 1; k <= 40; k++) begin
      drv(0, k == 3, 7, 32'hFFFF0000, 5'(k), 5'(k));
      busy0 += int'(i0.init_busy);
      busy2 += int'(i2.init_busy);
      if (k == 4) begin
        chk("init_drop0", 32'(i0.wr_drop), 1);
        chk("init_drop2", 32'(i2.wr_drop), 1);
      end
      if (k == 5) chk("init_drop_end", 32'(i0.wr_drop), 0);
      if (k == 20) chk("init_rd", i0.read_data1, 0);
    end
    chk("busy_len32", busy0, 32);
    chk("busy_len16", busy2, 16);
    for (int i = 0; i < 32; i++) begin
      drv(0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk("post_rd1", i0.read_data1, 0);
      chk("post_rd2", i0.read_data2, 0);
      chk("post_rd_d16", i2.read_data1, 0);
      chk("post_drop", 32'(i0.wr_drop), 0);
    end
    drv(0, 1, 5, 32'hDEADBEEF, 5, 5);
    chk("byp_rd1", i0.read_data1, 32'hDEADBEEF);
    chk("byp_rd2", i0.read_data2, 32'hDEADBEEF);
    chk("byp_d16", i2.read_data2, 32'hDEADBEEF);
    drv(0, 0, 0, 0, 5, 5);
    chk("arr_rd1", i0.read_data1, 32'hDEADBEEF);
    chk("arr_d16", i2.read_data2, 32'hDEADBEEF);
    chk("arr_drop", 32'(i0.wr_drop), 0);
    drv(0, 1, 0, 32'h12345678, 0, 0);
    chk("z_byp", i0.read_data1, 0);
    chk("nz_byp", i1.read_data1, 32'h12345678);
    drv(0, 0, 0, 0, 0, 0);
    chk("z_rd", i0.read_data1, 0);
    chk("z_drop", 32'(i0.wr_drop), 0);
    chk("nz_rd", i1.read_data1, 32'h12345678);
    drv(0, 1, 20, 32'hCAFEF00D, 20, 20);
    chk("oor_byp_d16", i2.read_data1, 0);
    chk("oor_byp_d32", i0.read_data1, 32'hCAFEF00D);
    drv(0, 0, 0, 0, 20, 20);
    chk("oor_drop_d16", 32'(i2.wr_drop), 1);
    chk("oor_drop_d32", 32'(i0.wr_drop), 0);
    chk("oor_rd_d16", i2.read_data2, 0);
    chk("oor_rd_d32", i0.read_data1, 32'hCAFEF00D);
    drv(0, 0, 0, 0, 7, 7);
    chk("oor_drop_end", 32'(i2.wr_drop), 0);
    chk("init_wr_lost", i0.read_data1, 0);
    chk("init_wr_lost16", i2.read_data2, 0);
    for (int i = 1; i < 32; i++) drv(0, 1, 5'(i), 32'h10000000 + 32'(i), 0, 0);
    drv(0, 0, 0, 0, 31, 9);
    chk("fill_r31", i0.read_data1, 32'h1000001F);
    chk("fill_r9", i0.read_data2, 32'h10000009);
    chk("fill_r9_d16", i2.read_data2, 32'h10000009);
    drv(1, 1, 3, 32'h33, 3, 31);
    chk("clr_req_busy", 32'(i0.init_busy), 0);
    chk("clr_req_byp", i0.read_data1, 32'h33);
    busy0 = 0; busy2 = 0;
    for (int k = 1; k <= 40; k++) begin
      drv(0, 0, 0, 0, 5'(k), 31);
      busy0 += int'(i0.init_busy);
      busy2 += int'(i2.init_busy);
      if (i0.init_busy) chk("clr_rd1", i0.read_data1, 0);
      if (i0.init_busy) chk("clr_rd2", i0.read_data2, 0);
    end
    chk("clr_len32", busy0, 32);
    chk("clr_len16", busy2, 16);
    drv(0, 0, 0, 0, 3, 31);
    chk("clr_r3", i0.read_data1, 0);
    chk("clr_r31", i0.read_data2, 0);
    drv(0, 1, 10, 32'h0000ABCD, 0, 0);
    drv(1, 0, 0, 0, 10, 0);
    chk("r10_set", i0.read_data1, 32'h0000ABCD);
    for (int k = 1; k <= 11; k++) drv(0, 0, 0, 0, 10, 0);
    chk("mid_clr_rd", i0.read_data1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(i0.init_busy), 1);
    chk("mid_rst_rd", i0.read_data1, 0);
    drv(0, 0, 0, 0, 10, 0);
    rst_n = 1'b1;
    busy0 = 1;
    for (int k = 1; k <= 40; k++) begin
      drv(0, 0, 0, 0, 10, 0);
      busy0 += int'(i0.init_busy);
    end
    chk("restart_len", busy0, 32);
    chk("restart_r10", i0.read_data1, 0);
`ifdef REGFILE_PARITY_EN
    inj = 1'b1;
    drv(0, 1, 3, 32'hA5A5A5A5, 3, 0);
    chk("par_byp", 32'(i0.parity_err1), 0);
    drv(0, 0, 0, 0, 3, 0);
    chk("par_inj", 32'(i0.parity_err1), 1);
    inj = 1'b0;
    drv(0, 1, 3, 32'hA5A5A5A5, 3, 0);
    drv(0, 0, 0, 0, 3, 3);
    chk("par_ok1", 32'(i0.parity_err1), 0);
    chk("par_ok2", 32'(i0.parity_err2), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
